// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction fetch path: word type, fetch states and
// the decode jump/branch codes.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    localparam logic [1:0] JUMP_NONE  = 2'b00;
    localparam logic [1:0] JUMP_JR    = 2'b01;
    localparam logic [1:0] JUMP_J     = 2'b10;
    localparam logic [1:0] JUMP_JAL   = 2'b11;

    localparam logic [1:0] BRANCH_NONE = 2'b00;
    localparam logic [1:0] BRANCH_BEQ  = 2'b01;
    localparam logic [1:0] BRANCH_BNE  = 2'b10;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for the held instruction: jump beats branch beats sequential.
// Only the instruction index field is passed in; its low 16 bits are the branch offset.
module pc_next
    import cpu_types_pkg::*;
(
    input  word_t       pc_plus4,
    input  logic [25:0] target,
    input  logic [1:0]  jump,
    input  logic [1:0]  branch,
    input  logic        zero,
    input  logic [29:0] jr_word,
    output word_t       next_pc
);

    logic  taken;
    word_t offset;

    always_comb begin
        taken   = ((branch == BRANCH_BEQ) && zero) || ((branch == BRANCH_BNE) && !zero);
        offset  = {{14{target[15]}}, target[15:0], 2'b00};
        next_pc = pc_plus4;
        if (jump == JUMP_JR) begin
            next_pc = {jr_word, 2'b00};
        end else if ((jump == JUMP_J) || (jump == JUMP_JAL)) begin
            next_pc = {pc_plus4[31:28], target, 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + offset;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch state machine: requests, latches and holds one instruction at a time.
// Optional FETCH_PERF_EN adds saturating fetch_count / wait_count outputs.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  word_t       imemload,
    output logic        iREN,
    output word_t       imemaddr,
    output word_t       instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic [1:0]  jump,
    input  logic [1:0]  branch,
    input  logic        zero,
    input  word_t       jr_addr,
    input  logic        halt,
    output word_t       pc_plus4,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output word_t       fetch_count,
    output word_t       wait_count
`endif
);

    fetch_state_t state;
    word_t        pc;
    word_t        next_pc;

    assign pc_plus4 = pc + 32'd4;
    assign imemaddr = pc;
    // Gate with RST so no request leaks out while reset is held.
    assign iREN     = (state == ST_FETCH) && !RST;

    pc_next u_pc_next (
        .pc_plus4 (pc_plus4),
        .target   (instr[25:0]),
        .jump     (jump),
        .branch   (branch),
        .zero     (zero),
        .jr_word  (jr_addr[31:2]),
        .next_pc  (next_pc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_FETCH;
            pc          <= PC_INIT;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (ihit) begin
                        instr       <= imemload;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= ST_HALTED;
                        end else begin
                            pc          <= next_pc;
                            instr_valid <= 1'b0;
                            state       <= ST_FETCH;
                        end
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_count <= '0;
            wait_count  <= '0;
        end else if (state == ST_FETCH) begin
            if (ihit) begin
                if (fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
            end else begin
                if (wait_count != 32'hFFFF_FFFF) wait_count <= wait_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected fetch addresses are queued when the
// decode inputs are driven and compared when the next request appears.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] imemaddr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic [1:0]  jump;
    logic [1:0]  branch;
    logic        zero;
    logic [31:0] jr_addr;
    logic        halt;
    logic [31:0] pc_plus4;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] wait_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .imemload    (imemload),
        .iREN        (iREN),
        .imemaddr    (imemaddr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero),
        .jr_addr     (jr_addr),
        .halt        (halt),
        .pc_plus4    (pc_plus4),
        .halted      (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .wait_count  (wait_count)
`endif
    );

    // Wait (bounded) for a request, stall it for 'waits' cycles, then deliver 'word'.
    // Returns the request address, or X when no request appeared.
    task automatic serve_fetch(input logic [31:0] word, input int waits, output logic [31:0] addr_seen);
        int n;
        n = 0;
        while (iREN !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (iREN !== 1'b1) begin
            addr_seen = 'x;
            return;
        end
        addr_seen = imemaddr;
        repeat (waits) begin
            ihit = 1'b0;
            @(negedge CLK);
        end
        imemload = word;
        ihit     = 1'b1;
        @(negedge CLK);
        ihit     = 1'b0;
    endtask

    task automatic hold_step(input logic [1:0] j, input logic [1:0] b, input logic z, input logic [31:0] jr);
        jump = j; branch = b; zero = z; jr_addr = jr; stall = 1'b0; halt = 1'b0;
        @(negedge CLK);
        jump = 2'b00; branch = 2'b00; zero = 1'b0; jr_addr = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rst_iren got %b want 0", iREN); end
        checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imemaddr); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
        exp_q.push_back(32'h0);
        RST = 1'b0;
    endtask

    task automatic test_fetch_latency();
        int cnt;
        logic [31:0] e;
        cnt = 0;
        e = exp_q.pop_front();
        for (int c = 0; c < 3; c++) begin
            #1;
            if (iREN === 1'b1) cnt++;
            checks++; if (imemaddr !== e) begin errors++; $display("FAIL first_addr cyc %0d got %h want %h", c, imemaddr, e); end
            imemload = 32'h0800_0040;
            ihit     = (c == 2);
            @(negedge CLK);
        end
        ihit = 1'b0;
        #1;
        checks++; if (cnt !== 3) begin errors++; $display("FAIL first_iren_cycles got %0d want 3", cnt); end
        checks++; if (instr !== 32'h0800_0040) begin errors++; $display("FAIL first_instr got %h want 08000040", instr); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", instr_valid); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL hold_iren got %b want 0", iREN); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL first_pc_plus4 got %h want 4", pc_plus4); end
    endtask

    task automatic test_branch();
        logic [31:0] a, e;
        exp_q.push_back(32'h100);
        hold_step(2'b10, 2'b00, 1'b0, 32'h0);
        serve_fetch(32'h1000_FFFF, 1, a); e = exp_q.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL j_target got %h want %h", a, e); end
        checks++; if (pc_plus4 !== 32'h104) begin errors++; $display("FAIL hold_pc_plus4 got %h want 104", pc_plus4); end
        exp_q.push_back(32'h100);
        hold_step(2'b00, 2'b01, 1'b1, 32'h0);
        serve_fetch(32'h1000_FFFF, 0, a); e = exp_q.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL beq_taken got %h want %h", a, e); end
        exp_q.push_back(32'h104);
        hold_step(2'b00, 2'b01, 1'b0, 32'h0);
        serve_fetch(32'h1400_FFFE, 0, a); e = exp_q.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL beq_not_taken got %h want %h", a, e); end
        exp_q.push_back(32'h100);
        hold_step(2'b00, 2'b10, 1'b0, 32'h0);
        serve_fetch(32'h0C00_0040, 0, a); e = exp_q.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL bne_taken got %h want %h", a, e); end
    endtask

    task automatic test_jump();
        logic [31:0] a, e;
        checks++; if (pc_plus4 !== 32'h104) begin errors++; $display("FAIL jal_pc_plus4 got %h want 104", pc_plus4); end
        exp_q.push_back(32'h100);
        hold_step(2'b11, 2'b00, 1'b0, 32'h0);
        serve_fetch(32'h0000_0008, 0, a); e = exp_q.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL jal_target got %h want %h", a, e); end
        exp_q.push_back(32'h200);
        hold_step(2'b01, 2'b00, 1'b0, 32'h203);
        serve_fetch(32'h1000_0010, 0, a); e = exp_q.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL jr_target got %h want %h", a, e); end
        exp_q.push_back(32'h204);
        hold_step(2'b00, 2'b11, 1'b1, 32'h0);
        serve_fetch(32'h0800_0080, 0, a); e = exp_q.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL branch11_ignored got %h want %h", a, e); end
        exp_q.push_back(32'h200);
        hold_step(2'b10, 2'b01, 1'b1, 32'h0);
        serve_fetch(32'h1234_5678, 0, a); e = exp_q.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL jump_over_branch got %h want %h", a, e); end
    endtask

    task automatic test_stall();
        logic [31:0] a, e;
        stall = 1'b1; ihit = 1'b1; imemload = 32'hDEAD_BEEF; jump = 2'b01; jr_addr = 32'h400;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL stall_instr cyc %0d got %h want 12345678", c, instr); end
            checks++; if (imemaddr !== 32'h200) begin errors++; $display("FAIL stall_addr cyc %0d got %h want 200", c, imemaddr); end
            checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL stall_iren cyc %0d got %b want 0", c, iREN); end
        end
        ihit = 1'b0; jump = 2'b00; jr_addr = '0;
        exp_q.push_back(32'h204);
        stall = 1'b0;
        @(negedge CLK);
        e = exp_q.pop_front();
        checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL unstall_iren got %b want 1", iREN); end
        checks++; if (imemaddr !== e) begin errors++; $display("FAIL unstall_addr got %h want %h", imemaddr, e); end
        serve_fetch(32'h0000_0000, 0, a);
    endtask

    task automatic test_wrap();
        logic [31:0] a, e;
        exp_q.push_back(32'hFFFF_FFFC);
        hold_step(2'b01, 2'b00, 1'b0, 32'hFFFF_FFFF);
        serve_fetch(32'h0000_0000, 0, a); e = exp_q.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL jr_top got %h want %h", a, e); end
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 got %h want 0", pc_plus4); end
        exp_q.push_back(32'h0);
        hold_step(2'b00, 2'b00, 1'b0, 32'h0);
        serve_fetch(32'hFFFF_FFFF, 0, a); e = exp_q.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL wrap_seq got %h want %h", a, e); end
    endtask

    task automatic test_halt();
        logic [31:0] a, e;
        exp_q.push_back(32'h300);
        hold_step(2'b01, 2'b00, 1'b0, 32'h300);
        serve_fetch(32'h0000_000C, 0, a); e = exp_q.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL pre_halt got %h want %h", a, e); end
        halt = 1'b1; stall = 1'b0;
        @(negedge CLK);
        for (int c = 0; c < 8; c++) begin
            ihit = ~ihit; imemload = $urandom; jump = 2'(c); stall = c[0]; halt = c[1];
            @(negedge CLK);
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_sticky cyc %0d got %b want 1", c, halted); end
            checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL halted_iren cyc %0d got %b want 0", c, iREN); end
            checks++; if (imemaddr !== 32'h300) begin errors++; $display("FAIL halted_pc cyc %0d got %h want 300", c, imemaddr); end
            checks++; if (instr_valid !== 1'b1 || instr !== 32'h0000_000C) begin errors++; $display("FAIL halted_instr cyc %0d got %b/%h want 1/0000000c", c, instr_valid, instr); end
        end
        ihit = 1'b0; jump = 2'b00; stall = 1'b0; halt = 1'b0;
        #2 RST = 1'b1;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_clears_halt got %b want 0", halted); end
        checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL rst_pc_init got %h want 0", imemaddr); end
        checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rst_iren_async got %b want 0", iREN); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        logic [31:0] a, e;
        exp_q.push_back(32'h0);
        serve_fetch(32'hAAAA_5555, 1, a); e = exp_q.pop_front();
        checks++; if (a !== e) begin errors++; $display("FAIL post_rst_fetch got %h want %h", a, e); end
        stall = 1'b1; jump = 2'b01; jr_addr = 32'h800;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_stall_rst got %h/%b want 0/0", instr, instr_valid); end
        stall = 1'b0;
        @(negedge CLK);
        jump = 2'b00; jr_addr = '0;
        RST = 1'b0;
        #1;
        checks++; if (iREN !== 1'b1 || imemaddr !== 32'h0) begin errors++; $display("FAIL mid_stall_restart got %b/%h want 1/0", iREN, imemaddr); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        logic [31:0] a;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) hold_step(2'b00, 2'b00, 1'b0, 32'h0);
            serve_fetch(32'h0000_0000, 2, a);
        end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL fetch_count got %0d want 3", fetch_count); end
        checks++; if (wait_count !== 32'd6) begin errors++; $display("FAIL wait_count got %0d want 6", wait_count); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; ihit = 1'b0; imemload = '0; stall = 1'b0; jump = 2'b00;
        branch = 2'b00; zero = 1'b0; jr_addr = '0; halt = 1'b0;
        @(negedge CLK);
        test_reset();
        test_fetch_latency();
        test_branch();
        test_jump();
        test_stall();
        test_wrap();
        test_halt();
        test_reset_mid_stall();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port ihit  input  1  instruction memory returns valid imemload this cycle.
REQ-005 SHALL have port imemload  input  32  instruction word from instruction memory.
REQ-006 SHALL have port iREN  output  1  instruction read request.
REQ-007 SHALL have port imemaddr  output  32  fetch address, equal to the current PC.
REQ-008 SHALL have port instr  output  32  latched instruction, presented to decode.
REQ-009 SHALL have port instr_valid  output  1  instr holds a fetched, not yet retired instruction.
REQ-010 SHALL have port stall  input  1  downstream busy (data access pending); hold the current instruction.
REQ-011 SHALL have port jump  input  2  decode jump code: 00 none, 01 JR, 10 J, 11 JAL.
REQ-012 SHALL have port branch  input  2  decode branch code: 00 none, 01 BEQ, 10 BNE.
REQ-013 SHALL have port zero  input  1  ALU zero flag for the held instruction.
REQ-014 SHALL have port jr_addr  input  32  rs register value for JR.
REQ-015 SHALL have port halt  input  1  decode flags the held instruction as HALT.
REQ-016 SHALL have port pc_plus4  output  32  PC+4 of the held instruction, the JAL link value.
REQ-017 SHALL have port halted  output  1  sticky halt indication.

Function
REQ-018 SHALL implement states FETCH, HOLD, HALTED.
REQ-019 FETCH: iREN=1, imemaddr=PC; on ihit, SHALL latch imemload into instr, set instr_valid=1, and go to HOLD on the next edge.
REQ-020 FETCH without ihit SHALL stay in FETCH with iREN held high; there is no request timeout.
REQ-021 HOLD: iREN=0, instr stable; while stall=1, SHALL keep state, PC and instr unchanged.
REQ-022 HOLD with stall=0 and halt=1: SHALL go to HALTED, keep the PC, and set halted=1.
REQ-023 HOLD with stall=0 and halt=0: SHALL load PC with next-PC, clear instr_valid, and go to FETCH.
REQ-024 Next-PC precedence SHALL be jump first, then branch, then sequential:
 - jump=01: {jr_addr[31:2],2'b00}.
 - jump=1x: {pc_plus4[31:28], instr[25:0], 2'b00}.
 - branch=01 with zero=1, or branch=10 with zero=0: pc_plus4 + (sign-extended instr[15:0] << 2).
 - otherwise: pc_plus4.
REQ-025 branch=11 SHALL be treated as no branch.
REQ-026 All PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-027 pc_plus4 SHALL equal PC+4 combinationally in every state.
REQ-028 HALTED: iREN=0, halted=1 and instr_valid=1; all inputs ignored until reset.
REQ-029 ihit asserted outside FETCH SHALL be ignored.

Reset
REQ-030 RST=1 SHALL asynchronously set PC=PC_INIT, state=FETCH, instr=0, instr_valid=0 and halted=0.
REQ-031 With RST=1, iREN SHALL be 0; the first request is issued in the first cycle after RST deasserts.
REQ-032 Reset mid-fetch or mid-stall SHALL abandon the instruction; no PC update occurs from it.

Configuration
REQ-033 When macro FETCH_PERF_EN is defined, the block SHALL add these outputs:
 - fetch_count (32): increments on each FETCH ihit.
 - wait_count (32): increments on each FETCH cycle without ihit.
 - Both counters saturate at 32'hFFFF_FFFF and are cleared by RST.
REQ-034 Without FETCH_PERF_EN, neither the ports nor the counters SHALL exist, and all other behaviour is identical.

Structure
REQ-035 cpu_types_pkg SHALL hold word_t, the fetch-state enum, and the jump/branch code constants.
REQ-036 Next-PC selection SHALL be one combinational sub-module, pc_next; the state machine and registers stay in fetch_unit.

Verification
REQ-037 Reset with PC_INIT=0, ihit=1 after 2 cycles -> imemaddr=0, iREN=1 for 3 cycles, then instr=imemload and instr_valid=1.
REQ-038 Held BEQ (instr[15:0]=16'hFFFF) at PC=0x100, zero=1 -> next imemaddr=0x100; zero=0 -> next imemaddr=0x104.
REQ-039 jump=11, instr[25:0]=26'h0000040 at PC=0x100 -> next imemaddr=0x100 and pc_plus4=0x104 during HOLD; jump=01 with jr_addr=0x203 -> next imemaddr=0x200.
REQ-040 stall=1 for 5 cycles in HOLD -> instr, PC and imemaddr are unchanged and iREN=0, then the update occurs in the cycle after stall drops.
REQ-041 halt=1 with stall=0 -> halted=1 forever and iREN=0 despite ihit toggling; RST -> halted=0 and imemaddr=PC_INIT.
REQ-042 With FETCH_PERF_EN, 3 fetches of 2 wait cycles each -> fetch_count=3 and wait_count=6.
